// File: rtl/rd_valid_generator_if.sv
// ============================================================================
// Module      : rd_valid_generator_if
// Description : Status/strobe bundle between FIFO full logic and the read-side
//               drain generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rd_valid_generator_if;
   logic full;
   logic rd_valid;

   // Producer of the full flag / consumer of the read strobe
   modport master (
      output full,
      input  rd_valid
   );

   // The drain generator itself
   modport slave (
      input  full,
      output rd_valid
   );
endinterface

`default_nettype wire

// File: rtl/rd_valid_generator.sv
// ============================================================================
// Module      : rd_valid_generator
// Description : Emits a FIFO_DEPTH-cycle rd_valid burst per synchronized
//               0->1 transition of the asynchronous FIFO full flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_valid_generator #(
   parameter int FIFO_DEPTH    = 8,
   parameter int COUNTER_WIDTH = 3
) (
   input  wire logic             rd_clk,
   input  wire logic             reset,
   rd_valid_generator_if.slave   bus
);

   localparam logic [COUNTER_WIDTH-1:0] c_last_count = COUNTER_WIDTH'(FIFO_DEPTH - 1);
   localparam logic [COUNTER_WIDTH-1:0] c_count_one  = COUNTER_WIDTH'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   logic                     r_full_s1;
   logic                     r_full_s2;
   logic                     r_full_s2_d;
   logic                     w_full_rise;

   state_t                   r_state;
   logic [COUNTER_WIDTH-1:0] r_count;
   logic                     r_rd_valid;

   // full is asynchronous to rd_clk: two-flop synchronizer plus edge-detect flop
   always_ff @(posedge rd_clk or negedge reset) begin
      if (!reset) begin
         r_full_s1   <= 1'b0;
         r_full_s2   <= 1'b0;
         r_full_s2_d <= 1'b0;
      end else begin
         r_full_s1   <= bus.full;
         r_full_s2   <= r_full_s1;
         r_full_s2_d <= r_full_s2;
      end
   end

   assign w_full_rise = r_full_s2 & ~r_full_s2_d;

   // Edges seen while draining are simply dropped; the edge flop keeps
   // tracking the level so nothing is queued for after the burst.
   always_ff @(posedge rd_clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_count    <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_count <= '0;
               if (w_full_rise) begin
                  r_state    <= ST_DRAIN;
                  r_rd_valid <= 1'b1;
               end else begin
                  r_rd_valid <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (r_count == c_last_count) begin
                  r_state    <= ST_IDLE;
                  r_count    <= '0;
                  r_rd_valid <= 1'b0;
               end else begin
                  r_count    <= r_count + c_count_one;
                  r_rd_valid <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_count    <= '0;
               r_rd_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_rd_valid_generator.sv
// ============================================================================
// Module      : tb_rd_valid_generator
// Description : Directed self-checking bench for rd_valid_generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rd_valid_generator;

   logic rd_clk;
   logic reset;
   int   checks;
   int   errors;

   rd_valid_generator_if bus ();

   rd_valid_generator #(
      .FIFO_DEPTH    (8),
      .COUNTER_WIDTH (3)
   ) dut (
      .rd_clk (rd_clk),
      .reset  (reset),
      .bus    (bus)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic expect_n(input string tag, input logic exp, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s[%0d]", tag, i), bus.rd_valid, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      bus.full = 1'b0;

      // Reset held while full toggles
      for (int i = 0; i < 6; i++) begin
         bus.full = ~bus.full;
         tick();
         check($sformatf("in_reset[%0d]", i), bus.rd_valid, 1'b0);
      end
      bus.full = 1'b0;
      expect_n("in_reset_quiet", 1'b0, 4);
      reset = 1'b1;
      expect_n("post_reset", 1'b0, 8);

      // Single drain: full high for 3 edges (k..k+2), burst on edges k+2..k+9
      bus.full = 1'b1;
      expect_n("single_lat", 1'b0, 2);
      expect_n("single_b0", 1'b1, 1);
      bus.full = 1'b0;
      expect_n("single_burst", 1'b1, 7);
      expect_n("single_after", 1'b0, 6);

      // Held full: one burst only over 30 cycles of high level
      bus.full = 1'b1;
      expect_n("held_lat", 1'b0, 2);
      expect_n("held_burst", 1'b1, 8);
      expect_n("held_no_retrig", 1'b0, 20);
      bus.full = 1'b0;
      expect_n("held_low", 1'b0, 4);
      bus.full = 1'b1;
      expect_n("held_rearm_lat", 1'b0, 2);
      expect_n("held_rearm_burst", 1'b1, 8);
      bus.full = 1'b0;
      expect_n("held_rearm_after", 1'b0, 6);

      // Second rise during burst cycle 4 is ignored
      bus.full = 1'b1;
      expect_n("retrig_lat", 1'b0, 2);
      bus.full = 1'b0;
      expect_n("retrig_b1_3", 1'b1, 3);
      bus.full = 1'b1;
      expect_n("retrig_b4_5", 1'b1, 2);
      bus.full = 1'b0;
      expect_n("retrig_b6_8", 1'b1, 3);
      expect_n("retrig_after", 1'b0, 12);

      // Two separate single-edge pulses 15 cycles apart
      bus.full = 1'b1;
      expect_n("two_a_lat0", 1'b0, 1);
      bus.full = 1'b0;
      expect_n("two_a_lat1", 1'b0, 1);
      expect_n("two_a_burst", 1'b1, 8);
      expect_n("two_gap", 1'b0, 6);
      bus.full = 1'b1;
      expect_n("two_b_lat0", 1'b0, 1);
      bus.full = 1'b0;
      expect_n("two_b_lat1", 1'b0, 1);
      expect_n("two_b_burst", 1'b1, 8);
      expect_n("two_b_after", 1'b0, 6);

      // Reset asserted in burst cycle 5 clears rd_valid without waiting for a clock
      bus.full = 1'b1;
      expect_n("rst_lat", 1'b0, 2);
      bus.full = 1'b0;
      expect_n("rst_burst", 1'b1, 5);
      #2;
      reset = 1'b0;
      #1;
      check("rst_async_drop", bus.rd_valid, 1'b0);
      expect_n("rst_held", 1'b0, 3);
      reset = 1'b1;
      expect_n("rst_released", 1'b0, 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
